// File: rtl/mem_core_bus_controller.sv
// Main-memory controller behind the core's merged memory bus.
// Line requests are queued in a small FIFO and serviced one at a time with a
// fixed access latency; each completion produces a one-cycle tagged response.
// The line-wide backing store lives here and is never cleared by reset.
module mem_core_bus_controller #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned LINE_WIDTH  = 128,
    parameter int unsigned ID_WIDTH    = 1,
    parameter int unsigned DEPTH_LINES = 4096,
    parameter int unsigned LATENCY     = 5,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic [ID_WIDTH-1:0]   req_id,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LINE_WIDTH-1:0] req_data,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [ID_WIDTH-1:0]   resp_id,
    output logic [ADDR_WIDTH-1:0] resp_addr,
    output logic [LINE_WIDTH-1:0] resp_data
);

    localparam int unsigned OFF_W = $clog2(LINE_WIDTH / 8);
    localparam int unsigned IDX_W = $clog2(DEPTH_LINES);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK  = {ADDR_WIDTH{1'b1}} << OFF_W;
    localparam logic [CNT_W-1:0]      CNT_START  = CNT_W'(LATENCY - 1);
    localparam logic [PTR_W:0]        COUNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESPOND
    } state_t;

    // Pending-request queue
    logic                  fifo_wr   [FIFO_DEPTH];
    logic [ID_WIDTH-1:0]   fifo_id   [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
    logic [LINE_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [PTR_W:0]        count_q;

    // Backing store
    logic [LINE_WIDTH-1:0] mem [DEPTH_LINES];

    // Request currently being serviced
    logic                  w_write_q;
    logic [ID_WIDTH-1:0]   w_id_q;
    logic [ADDR_WIDTH-1:0] w_addr_q;
    logic [LINE_WIDTH-1:0] w_data_q;
    logic [IDX_W-1:0]      w_idx;

    state_t                state_q;
    state_t                state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic                  push;
    logic                  pop;
    logic                  do_access;

    // Ready depends only on the registered occupancy; a same-cycle pop never bypasses a full queue.
    assign req_ready = (count_q != COUNT_FULL);
    assign push      = (req_read | req_write) & req_ready;
    assign w_idx     = w_addr_q[OFF_W +: IDX_W];

    // Queue entry storage; a simultaneous read+write request is stored as a write.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_wr[wr_ptr_q]   <= req_write;
            fifo_id[wr_ptr_q]   <= req_id;
            fifo_addr[wr_ptr_q] <= req_addr & ADDR_MASK;
            fifo_data[wr_ptr_q] <= req_data;
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Next-state logic: pop in IDLE or RESPOND, count down in ACCESS, access memory when the count expires.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pop       = 1'b0;
        do_access = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    cnt_d   = CNT_START;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    do_access = 1'b1;
                    state_d   = RESPOND;
                end
            end
            RESPOND: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    cnt_d   = CNT_START;
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register and latency counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Load the queue head into the working registers when it is popped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            w_write_q <= 1'b0;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_data_q  <= '0;
        end else if (pop) begin
            w_write_q <= fifo_wr[rd_ptr_q];
            w_id_q    <= fifo_id[rd_ptr_q];
            w_addr_q  <= fifo_addr[rd_ptr_q];
            w_data_q  <= fifo_data[rd_ptr_q];
        end
    end

    // Commit writes at the end of the access window (no reset: contents survive reset).
    always_ff @(posedge clock) begin
        if (do_access && w_write_q) begin
            mem[w_idx] <= w_data_q;
        end
    end

    // Response registers: strobe for the RESPOND cycle, payload held until the next completion.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_addr  <= '0;
            resp_data  <= '0;
        end else begin
            resp_valid <= do_access;
            if (do_access) begin
                resp_id   <= w_id_q;
                resp_addr <= w_addr_q;
                resp_data <= w_write_q ? w_data_q : mem[w_idx];
            end
        end
    end

endmodule

// File: tb/tb_mem_core_bus_controller.sv
// Self-checking bench for mem_core_bus_controller: directed scenarios with
// literal expectations plus randomized traffic against a transaction model.
module tb_mem_core_bus_controller;

    localparam int AW  = 32;
    localparam int LW  = 128;
    localparam int IW  = 1;
    localparam int DL  = 4096;
    localparam int LAT = 5;
    localparam int FD  = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          req_read = 1'b0;
    logic          req_write = 1'b0;
    logic [IW-1:0] req_id = '0;
    logic [AW-1:0] req_addr = '0;
    logic [LW-1:0] req_data = '0;
    logic          req_ready;
    logic          resp_valid;
    logic [IW-1:0] resp_id;
    logic [AW-1:0] resp_addr;
    logic [LW-1:0] resp_data;

    mem_core_bus_controller #(
        .ADDR_WIDTH (AW),
        .LINE_WIDTH (LW),
        .ID_WIDTH   (IW),
        .DEPTH_LINES(DL),
        .LATENCY    (LAT),
        .FIFO_DEPTH (FD)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_read  (req_read),
        .req_write (req_write),
        .req_id    (req_id),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .resp_id   (resp_id),
        .resp_addr (resp_addr),
        .resp_data (resp_data)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    bit run_en   = 1'b0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // Each accepted request gets the edge V at which its access happens:
    // V = max(accept_edge + LAT + 1, previous V + LAT + 1); it leaves the queue at V - LAT.
    typedef struct {
        logic          wr;
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
        int            v;
    } mreq_t;

    mreq_t         mq[$];
    logic [LW-1:0] mmem[int];
    int            edge_n  = 0;
    int            vprev   = -100;
    logic          m_valid = 1'b0;
    logic          m_ready = 1'b1;
    logic [IW-1:0] m_id    = '0;
    logic [AW-1:0] m_addr  = '0;
    logic [LW-1:0] m_data  = '0;
    bit            m_known = 1'b1;

    initial forever begin
        mreq_t r;
        int    pend;
        int    idx;
        @(posedge clock or negedge reset);
        if (!reset) begin
            mq.delete();
            vprev   = -100;
            m_valid = 1'b0;
            m_ready = 1'b1;
            m_id    = '0;
            m_addr  = '0;
            m_data  = '0;
            m_known = 1'b1;
        end else begin
            edge_n++;
            if ((req_read || req_write) && m_ready) begin
                r.wr   = req_write;
                r.id   = req_id;
                r.addr = req_addr & 32'hFFFF_FFF0;
                r.data = req_data;
                r.v    = (edge_n + LAT + 1 > vprev + LAT + 1) ? edge_n + LAT + 1 : vprev + LAT + 1;
                vprev  = r.v;
                mq.push_back(r);
            end
            m_valid = 1'b0;
            if (mq.size() > 0 && mq[0].v == edge_n) begin
                idx = int'((mq[0].addr / 16) % DL);
                if (mq[0].wr) begin
                    mmem[idx] = mq[0].data;
                    m_data    = mq[0].data;
                    m_known   = 1'b1;
                end else if (mmem.exists(idx)) begin
                    m_data  = mmem[idx];
                    m_known = 1'b1;
                end else begin
                    m_known = 1'b0;
                end
                m_id    = mq[0].id;
                m_addr  = mq[0].addr;
                m_valid = 1'b1;
                void'(mq.pop_front());
            end
            pend = 0;
            foreach (mq[i]) if (mq[i].v - LAT > edge_n) pend++;
            m_ready = (pend != FD);
        end
    end

    // ---------------- compare process ----------------
    typedef struct {
        int            e;
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
    } rlog_t;

    rlog_t rlog[$];

    initial forever begin
        rlog_t l;
        @(negedge clock);
        if (run_en) begin
            chk("resp_valid", resp_valid, m_valid);
            chk("req_ready", req_ready, m_ready);
            chk("resp_id", resp_id, m_id);
            chk("resp_addr", resp_addr, m_addr);
            if (m_known) chk("resp_data", resp_data, m_data);
            if (resp_valid === 1'b1) begin
                l.e = edge_n; l.id = resp_id; l.addr = resp_addr; l.data = resp_data;
                rlog.push_back(l);
            end
        end
    end

    // ---------------- driver helpers (called at posedge+1) ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic issue(input bit rd, input bit wr, input logic [IW-1:0] id,
                         input logic [AW-1:0] a, input logic [LW-1:0] d, output int acc_edge);
        bit r;
        req_read = rd; req_write = wr; req_id = id; req_addr = a; req_data = d;
        acc_edge = -1;
        for (int k = 0; k < 200; k++) begin
            r = req_ready;
            tick(1);
            if (r) begin
                acc_edge = edge_n;
                break;
            end
        end
        req_read = 1'b0; req_write = 1'b0;
        if (acc_edge < 0) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_log(input int n);
        int k;
        for (k = 0; k < 1000; k++) begin
            if (rlog.size() >= n) break;
            tick(1);
        end
        if (rlog.size() < n) chk("resp_timeout", rlog.size(), n);
    endtask

    function automatic logic [LW-1:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int t0, t1, t5, ta;
        int pool[8] = '{0, 1, 2, 5, 100, 4095, 7, 8};
        logic [LW-1:0] d3, d4, d5;

        reset = 1'b0;
        tick(2);
        run_en = 1'b1;
        tick(2);
        reset = 1'b1;

        // idle after reset
        rlog.delete();
        tick(20);
        chk("t1_no_resp", rlog.size(), 0);
        chk("t1_ready", req_ready, 1);

        // write then read of the same line, latency and ordering
        rlog.delete();
        issue(0, 1, 0, 32'h40, {16{8'hA5}}, t1);
        issue(1, 0, 1, 32'h4C, '0, ta);
        wait_log(2);
        if (rlog.size() >= 2) begin
            chk("t2_first_latency", rlog[0].e + 1 - t1, 7);
            chk("t2_first_id", rlog[0].id, 0);
            chk("t2_gap", rlog[1].e - rlog[0].e, 6);
            chk("t2_second_id", rlog[1].id, 1);
            chk("t2_second_addr", rlog[1].addr, 32'h40);
            chk("t2_second_data", rlog[1].data, {16{8'hA5}});
        end
        tick(3);

        // queue fill: busy write plus reads until the queue is full
        rlog.delete();
        d3 = rnd_line();
        issue(0, 1, 0, 32'h300, d3, t0);
        for (int i = 0; i < 4; i++) issue(1, 0, IW'(i), 32'h300 + 32'(16 * i), '0, ta);
        chk("t3_full_ready", req_ready, 0);
        issue(1, 0, 0, 32'h340, '0, t5);
        chk("t3_fifth_accept", t5 - t0, 8);
        wait_log(6);
        if (rlog.size() >= 6) begin
            chk("t3_write_data", rlog[0].data, d3);
            chk("t3_read0_data", rlog[1].data, d3);
            for (int i = 1; i < 6; i++) begin
                chk("t3_spacing", rlog[i].e - rlog[i-1].e, 6);
                chk("t3_order", rlog[i].addr, 32'h300 + 32'(16 * (i - 1)));
            end
        end
        tick(3);

        // line index wraps modulo DEPTH_LINES
        rlog.delete();
        d4 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        issue(0, 1, 0, 32'h10000, d4, ta);
        issue(1, 0, 1, 32'h0, '0, ta);
        wait_log(2);
        if (rlog.size() >= 2) begin
            chk("t4_write_addr", rlog[0].addr, 32'h10000);
            chk("t4_alias_data", rlog[1].data, d4);
            chk("t4_read_addr", rlog[1].addr, 32'h0);
        end
        tick(3);

        // reset during an access drops all queued work, storage survives
        rlog.delete();
        d5 = rnd_line();
        issue(0, 1, 0, 32'h200, d5, ta);
        wait_log(1);
        issue(1, 0, 1, 32'h200, '0, ta);
        issue(1, 0, 0, 32'h210, '0, ta);
        issue(1, 0, 1, 32'h220, '0, ta);
        tick(2);
        reset = 1'b0;
        tick(3);
        reset = 1'b1;
        rlog.delete();
        tick(30);
        chk("t5_no_resp", rlog.size(), 0);
        issue(1, 0, 1, 32'h200, '0, ta);
        wait_log(1);
        if (rlog.size() >= 1) chk("t5_data_intact", rlog[0].data, d5);
        tick(3);

        // read and write together count as a write
        rlog.delete();
        issue(1, 1, 0, 32'h80, 128'h1, ta);
        issue(1, 0, 1, 32'h80, '0, ta);
        wait_log(2);
        if (rlog.size() >= 2) begin
            chk("t6_both_data", rlog[0].data, 128'h1);
            chk("t6_read_data", rlog[1].data, 128'h1);
        end
        tick(3);

        // randomized traffic over a small set of lines with aliased upper address bits
        foreach (pool[i]) issue(0, 1, IW'($urandom_range(0, 1)),
                                {16'($urandom), 12'(pool[i]), 4'($urandom)}, rnd_line(), ta);
        for (int n = 0; n < 400; n++) begin
            int k;
            logic [AW-1:0] a;
            k = $urandom_range(0, 9);
            a = {16'($urandom), 12'(pool[$urandom_range(0, 7)]), 4'($urandom)};
            if (k <= 4)      issue(1, 0, IW'($urandom_range(0, 1)), a, rnd_line(), ta);
            else if (k <= 8) issue(0, 1, IW'($urandom_range(0, 1)), a, rnd_line(), ta);
            else             issue(1, 1, IW'($urandom_range(0, 1)), a, rnd_line(), ta);
            if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 8));
            if ($urandom_range(0, 79) == 0) begin
                reset = 1'b0;
                tick($urandom_range(1, 3));
                reset = 1'b1;
            end
        end
        tick(60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
